traffic_light_sequencer: RTL
============================

// Module: traffic_light_sequencer
// PURPOSE
//  Parametrised red/amber/green phase sequencer for the VGA monitor demo. Phase dwell is
//  timed in ticks from an internal clock prescaler, and green is held until a progressive
//  or regressive request arrives. The state, lamp and remaining-time outputs drive the
//  on-screen display logic.
// PARAMETERS
//  CNT_W        8   width of phase countdown and remaining output
//  DIV_W        16  width of tick prescaler
//  TICK_DIV     1   clk cycles per tick (1 = tick every cycle); range 1..2^DIV_W-1
//  RED_TICKS    3   red dwell in ticks; range 1..2^CNT_W-1
//  AMBER_TICKS  2   amber dwell in ticks; range 1..2^CNT_W-1
//  GREEN_TICKS  4   minimum green dwell in ticks; range 1..2^CNT_W-1
// PORTS
//  clk          in   1      system clock; all logic on rising edge
//  reset        in   1      synchronous, active-high reset
//  start        in   1      begin sequencing; sampled only in IDLE
//  progressive  in   1      request normal exit from green (via amber)
//  regressive   in   1      request immediate exit from green (straight to red)
//  state        out  2      0=IDLE 1=RED 2=AMBER 3=GREEN
//  light        out  3      one-hot {red,amber,green}
//  remaining    out  CNT_W  ticks left in current phase (0 in IDLE / green min dwell met)
//  phase_done   out  1      1-cycle pulse on the cycle a timed phase expires
//  cycle_count  out  8      completed RED->AMBER->GREEN->exit cycles, wraps 255->0
// BEHAVIOUR
//  - All outputs are registered. On reset: state=IDLE, light=3'b100, remaining=0,
//    phase_done=0, cycle_count=0, prescaler=0, pending request=none.
//  - Tick: prescaler counts 0..TICK_DIV-1, tick=1 when it equals TICK_DIV-1.
//    The prescaler clears on every state change and while in IDLE.
//  - Phase entry loads remaining with that phase's *_TICKS. Each tick decrements it.
//  - A timed phase expires on a tick with remaining==1. Each phase therefore lasts exactly
//    *_TICKS*TICK_DIV cycles.
//  - IDLE: light red; start=1 at edge k -> RED at k+1, remaining=RED_TICKS.
//  - RED: on expiry -> AMBER, phase_done=1 for one cycle.
//  - AMBER: on expiry -> GREEN, phase_done=1.
//  - GREEN: counts down GREEN_TICKS. At expiry phase_done=1 and remaining goes 0 and holds.
//    - With remaining==0: progressive -> AMBER_EXIT; regressive -> RED.
//      Exit happens on the next edge.
//    - Requests seen while remaining>0 are latched as pending. Regressive overrides
//      progressive. The pending request is acted on the cycle after expiry.
//    - Same-cycle progressive & regressive: regressive wins.
//  - AMBER_EXIT: encoded as state=2, light amber, AMBER_TICKS dwell, then RED.
//    An internal flag distinguishes it from the entry amber.
//  - cycle_count increments by 1 on each GREEN exit (either request), wraps mod 256.
//  - RED after an exit re-enters the normal sequence; IDLE is reached only via reset.
//  - start outside IDLE and requests outside GREEN are ignored and never latched.
//  - Reset mid-phase wins over every other input on that edge. The pending request is cleared.
//  - Countdown never underflows; remaining saturates at 0 in GREEN only.
// TESTING (defaults unless noted)
//  1. Reset, start pulse at cycle 5 -> RED cycles 6-8, AMBER 9-10, GREEN from 11.
//     remaining 3,2,1 / 2,1 / 4..1 then 0; phase_done at 8, 10, 14.
//  2. In GREEN with remaining==0, progressive 1 cycle -> AMBER 2 cycles, then RED.
//     cycle_count 0->1 at GREEN exit.
//  3. regressive at GREEN remaining=3 -> stays GREEN until expiry, then RED next cycle.
//     No amber; cycle_count +1.
//  4. progressive and regressive together at remaining==0 -> RED directly.
//     start pulses in RED and AMBER have no effect.
//  5. TICK_DIV=4, RED_TICKS=2 -> RED lasts 8 cycles, remaining steps every 4 cycles.
//     Reset asserted mid-AMBER -> IDLE, light=3'b100, remaining=0 next cycle.
//  6. 256 forced cycles (small tick counts) -> cycle_count wraps 255->0.
//     light stays one-hot every cycle.

Source files
------------

// File: rtl/traffic_light_sequencer.sv
// Red/amber/green phase sequencer: prescaled tick countdown per phase, with green held
// after its minimum dwell until a progressive (via amber) or regressive (to red) request.
module traffic_light_sequencer #(
  parameter int CNT_W       = 8,
  parameter int DIV_W       = 16,
  parameter int TICK_DIV    = 1,
  parameter int RED_TICKS   = 3,
  parameter int AMBER_TICKS = 2,
  parameter int GREEN_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             progressive,
  input  logic             regressive,
  output logic [1:0]       state,
  output logic [2:0]       light,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_done,
  output logic [7:0]       cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RED   = 2'd1,
    ST_AMBER = 2'd2,
    ST_GREEN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_PROG = 2'd1,
    REQ_REG  = 2'd2
  } req_e;

  localparam logic [DIV_W-1:0] TICK_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RED_LOAD   = CNT_W'(RED_TICKS);
  localparam logic [CNT_W-1:0] AMBER_LOAD = CNT_W'(AMBER_TICKS);
  localparam logic [CNT_W-1:0] GREEN_LOAD = CNT_W'(GREEN_TICKS);

  state_e           state_q, state_d;
  logic             exit_q, exit_d;         // set while the amber is the green-exit amber
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  req_e             pend_q, pend_d, req_now;
  logic [2:0]       light_q, light_d;
  logic             phase_done_q, phase_done_d;
  logic [7:0]       cycle_q, cycle_d;
  logic             tick;
  logic             expire;

  assign tick   = (presc_q == TICK_LAST);
  assign expire = tick && (remaining_q == CNT_ONE);

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case leaves
    // it unassigned; a missing default would infer a latch.
    state_d     = state_q;
    exit_d      = exit_q;
    remaining_d = remaining_q;
    pend_d      = pend_q;
    cycle_d     = cycle_q;

    // Requests seen this cycle folded into the latched one; regressive dominates.
    req_now = pend_q;
    if (progressive && (pend_q == REQ_NONE)) req_now = REQ_PROG;
    if (regressive)                          req_now = REQ_REG;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RED;
          remaining_d = RED_LOAD;
        end
      end
      ST_RED: begin
        if (expire) begin
          state_d     = ST_AMBER;
          exit_d      = 1'b0;
          remaining_d = AMBER_LOAD;
        end else if (tick) begin
          remaining_d = remaining_q - CNT_ONE;
        end
      end
      ST_AMBER: begin
        if (expire) begin
          state_d     = exit_q ? ST_RED : ST_GREEN;
          remaining_d = exit_q ? RED_LOAD : GREEN_LOAD;
          exit_d      = 1'b0;
        end else if (tick) begin
          remaining_d = remaining_q - CNT_ONE;
        end
      end
      ST_GREEN: begin
        if (remaining_q == '0) begin
          if (req_now != REQ_NONE) begin
            state_d     = (req_now == REQ_REG) ? ST_RED : ST_AMBER;
            exit_d      = (req_now == REQ_PROG);
            remaining_d = (req_now == REQ_REG) ? RED_LOAD : AMBER_LOAD;
            pend_d      = REQ_NONE;
            cycle_d     = cycle_q + 8'd1;
          end
        end else begin
          pend_d = req_now;
          if (tick) remaining_d = remaining_q - CNT_ONE;
        end
      end
      default: ;
    endcase

    presc_d = (state_d != state_q || state_q == ST_IDLE || tick) ? '0 : presc_q + DIV_ONE;

    unique case (state_d)
      ST_AMBER: light_d = 3'b010;
      ST_GREEN: light_d = 3'b001;
      default:  light_d = 3'b100;
    endcase

    // Registered pulse: raised for the cycle in which the next tick will expire the phase.
    phase_done_d = (state_d != ST_IDLE) && (remaining_d == CNT_ONE) && (presc_d == TICK_LAST);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it lives inside the clocked branch and every
    // register, including the pending request, returns to a defined value on that edge.
    if (reset) begin
      state_q      <= ST_IDLE;
      exit_q       <= 1'b0;
      remaining_q  <= '0;
      presc_q      <= '0;
      pend_q       <= REQ_NONE;
      light_q      <= 3'b100;
      phase_done_q <= 1'b0;
      cycle_q      <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
      state_q      <= state_d;
      exit_q       <= exit_d;
      remaining_q  <= remaining_d;
      presc_q      <= presc_d;
      pend_q       <= pend_d;
      light_q      <= light_d;
      phase_done_q <= phase_done_d;
      cycle_q      <= cycle_d;
    end
  end

  assign state       = state_q;
  assign light       = light_q;
  assign remaining   = remaining_q;
  assign phase_done  = phase_done_q;
  assign cycle_count = cycle_q;

endmodule
